// File: rtl/sd_sector_loader_pkg.sv
// Shared definitions for the SD sector loader: FSM state encodings and sector geometry.
package sd_sector_loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WAIT_RDY = 3'd1,
        S_ISSUE    = 3'd2,
        S_RECV     = 3'd3,
        S_GAP      = 3'd4,
        S_DONE     = 3'd5,
        S_ERROR    = 3'd6
    } state_t;

    localparam int unsigned SECTOR_SHIFT           = 9;
    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 25_000_000;

endpackage

// File: rtl/sd_edge_strobe.sv
// Rising-edge detector on the SD byte strobe plus a one-cycle data capture register.
module sd_edge_strobe (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       byte_available,
    input  logic [7:0] din,
    output logic       byte_edge,
    output logic       strobe,
    output logic [7:0] data
);

    logic avail_q;

    assign byte_edge = byte_available & ~avail_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            avail_q <= 1'b0;
            strobe  <= 1'b0;
            data    <= '0;
        end else begin
            avail_q <= byte_available;
            strobe  <= enable & byte_edge;
            if (enable & byte_edge)
                data <= din;
        end
    end

endmodule

// File: rtl/sd_sector_loader.sv
// Reads a contiguous run of sectors from the SD controller and streams each byte
// into a write-only memory port with an incrementing, wrapping byte address.
module sd_sector_loader
    import sd_sector_loader_pkg::*;
#(
    parameter int unsigned MEM_AW         = 16,
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter int unsigned SECTOR_BYTES   = 512
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [22:0]       start_sector,
    input  logic [15:0]       num_sectors,
    input  logic              sd_ready,
    input  logic              sd_byte_available,
    input  logic [7:0]        sd_dout,
    output logic              sd_rd,
    output logic [31:0]       sd_address,
    output logic              mem_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [7:0]        mem_data,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [15:0]       sectors_done,
    output logic [2:0]        state_code
);

    localparam int unsigned    BW           = $clog2(SECTOR_BYTES);
    localparam logic [BW-1:0]  LAST_BYTE    = BW'(SECTOR_BYTES - 1);
    localparam logic [31:0]    TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);

    state_t        state, next_state;
    logic [15:0]   num_q;
    logic [22:0]   cur_sector;
    logic [BW-1:0] byte_cnt;
    logic [31:0]   timer;
    logic [15:0]   sectors_next;
    logic          accept, active, byte_edge, recv_edge, last_byte, timed_out;

    sd_edge_strobe u_edge (
        .clk            (clk),
        .reset          (reset),
        .enable         (state == S_RECV),
        .byte_available (sd_byte_available),
        .din            (sd_dout),
        .byte_edge      (byte_edge),
        .strobe         (mem_we),
        .data           (mem_data)
    );

    assign accept       = start && !busy &&
                          (state == S_IDLE || state == S_DONE || state == S_ERROR);
    assign active       = (state == S_WAIT_RDY) || (state == S_ISSUE) ||
                          (state == S_RECV)     || (state == S_GAP);
    assign recv_edge    = (state == S_RECV) && byte_edge;
    assign last_byte    = recv_edge && (byte_cnt == LAST_BYTE);
    assign timed_out    = active && (timer == TIMEOUT_LAST);
    assign sectors_next = sectors_done + 16'd1;

    assign sd_rd      = (state == S_ISSUE);
    assign sd_address = 32'(cur_sector) << SECTOR_SHIFT;
    assign state_code = state;

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE, S_DONE, S_ERROR:
                if (accept)
                    next_state = (num_sectors == '0) ? S_DONE : S_WAIT_RDY;
            S_WAIT_RDY: if (sd_ready)  next_state = S_ISSUE;
            S_ISSUE:    if (!sd_ready) next_state = S_RECV;
            // A byte edge coinciding with sd_ready is counted before the short-sector check.
            S_RECV: begin
                if (last_byte)     next_state = S_GAP;
                else if (sd_ready) next_state = S_ERROR;
            end
            S_GAP:
                if (sd_ready)
                    next_state = (sectors_next == num_q) ? S_DONE : S_ISSUE;
            default: next_state = S_IDLE;
        endcase
        if (timed_out)
            next_state = S_ERROR;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            num_q        <= '0;
            cur_sector   <= '0;
            sectors_done <= '0;
            byte_cnt     <= '0;
            timer        <= '0;
            mem_addr     <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
        end else begin
            state <= next_state;
            // Busy drops on the cycle done pulses, one cycle after DONE is entered.
            done  <= (state == S_DONE) && busy;

            if (accept) begin
                num_q        <= num_sectors;
                cur_sector   <= start_sector;
                sectors_done <= '0;
                busy         <= 1'b1;
                error        <= 1'b0;
            end else begin
                if (state == S_DONE || next_state == S_ERROR)
                    busy <= 1'b0;
                if (next_state == S_ERROR)
                    error <= 1'b1;
            end

            if (accept)
                mem_addr <= '0;
            else if (mem_we)
                mem_addr <= mem_addr + MEM_AW'(1);

            if (state == S_ISSUE)
                byte_cnt <= '0;
            else if (recv_edge)
                byte_cnt <= byte_cnt + BW'(1);

            if (state == S_GAP && sd_ready) begin
                sectors_done <= sectors_next;
                cur_sector   <= cur_sector + 23'd1;
            end

            if (!active || next_state != state || recv_edge)
                timer <= '0;
            else
                timer <= timer + 32'd1;
        end
    end

endmodule

// File: tb/tb_sd_sector_loader.sv
// Scoreboard bench for sd_sector_loader: a directed SD controller model pushes the
// expected memory writes, and a negedge monitor pops and compares each mem_we.
module tb_sd_sector_loader;

    logic        clk = 1'b0;
    logic        reset, start, sd_ready, sd_byte_available;
    logic [22:0] start_sector;
    logic [15:0] num_sectors;
    logic [7:0]  sd_dout;
    logic        sd_rd, mem_we, busy, done, error;
    logic [31:0] sd_address;
    logic [15:0] mem_addr, sectors_done;
    logic [7:0]  mem_data;
    logic [2:0]  state_code;

    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  data;
    } wr_t;

    wr_t         exp_q[$];
    logic [15:0] exp_addr;
    int          n_cmp = 0, n_bad = 0, n_writes = 0, n_done = 0, n_rd = 0;

    sd_sector_loader #(
        .MEM_AW         (16),
        .TIMEOUT_CYCLES (100),
        .SECTOR_BYTES   (512)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .start             (start),
        .start_sector      (start_sector),
        .num_sectors       (num_sectors),
        .sd_ready          (sd_ready),
        .sd_byte_available (sd_byte_available),
        .sd_dout           (sd_dout),
        .sd_rd             (sd_rd),
        .sd_address        (sd_address),
        .mem_we            (mem_we),
        .mem_addr          (mem_addr),
        .mem_data          (mem_data),
        .busy              (busy),
        .done              (done),
        .error             (error),
        .sectors_done      (sectors_done),
        .state_code        (state_code)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the oldest outstanding expected byte.
    always @(negedge clk) begin
        wr_t w;
        if (done === 1'b1)  n_done++;
        if (sd_rd === 1'b1) n_rd++;
        if (mem_we === 1'b1) begin
            n_writes++;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write",
                         mem_addr, mem_data);
            end else begin
                w = exp_q.pop_front();
                chk("mem_addr", 32'(mem_addr), 32'(w.addr));
                chk("mem_data", 32'(mem_data), 32'(w.data));
            end
        end
    end

    task automatic pulse_start(input logic [22:0] sector, input logic [15:0] num);
        @(posedge clk); #1;
        start_sector = sector;
        num_sectors  = num;
        start        = 1'b1;
        exp_addr     = '0;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // SD controller model for one sector: answer sd_rd, then stream nbytes.
    task automatic serve(input logic [31:0] exp_address, input int nbytes, input int hold,
                         input bit raise_ready, input logic [7:0] seed);
        int          k = 0;
        logic [7:0]  b;
        wr_t         w;
        while (sd_rd !== 1'b1 && k < 50) begin @(posedge clk); #1; k++; end
        chk("sd_rd_seen", 32'(sd_rd), 1);
        if (sd_rd !== 1'b1) return;
        chk("sd_address", sd_address, exp_address);
        @(posedge clk); #1;
        sd_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < nbytes; i++) begin
            b = 8'(i * 7) + seed;
            sd_dout = b;
            sd_byte_available = 1'b1;
            w.addr = exp_addr;
            w.data = b;
            exp_q.push_back(w);
            exp_addr = exp_addr + 16'd1;
            repeat (hold) @(posedge clk);
            #1;
            sd_byte_available = 1'b0;
            repeat (2) @(posedge clk);
            #1;
        end
        if (raise_ready) begin
            repeat (3) @(posedge clk);
            #1;
            sd_ready = 1'b1;
        end
    endtask

    task automatic wait_done(input logic [15:0] exp_sectors);
        int k = 0;
        while (done !== 1'b1 && k < 200) begin @(posedge clk); #1; k++; end
        chk("done_seen", 32'(done), 1);
        chk("busy_at_done", 32'(busy), 0);
        chk("sectors_done", 32'(sectors_done), 32'(exp_sectors));
    endtask

    task automatic wait_error();
        int k = 0;
        while (state_code !== 3'd6 && k < 200) begin @(posedge clk); #1; k++; end
        chk("err_state_code", 32'(state_code), 6);
        chk("err_flag", 32'(error), 1);
        chk("err_busy", 32'(busy), 0);
        chk("err_sd_rd", 32'(sd_rd), 0);
    endtask

    initial begin
        int w0, d0, r0, cnt;
        reset = 1'b1; start = 1'b0; sd_ready = 1'b1; sd_byte_available = 1'b0;
        sd_dout = '0; start_sector = '0; num_sectors = '0; exp_addr = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_state_code", 32'(state_code), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_error", 32'(error), 0);
        chk("rst_sd_rd", 32'(sd_rd), 0);
        chk("rst_mem_we", 32'(mem_we), 0);
        chk("rst_sd_address", sd_address, 0);
        chk("rst_mem_addr", 32'(mem_addr), 0);
        chk("rst_sectors_done", 32'(sectors_done), 0);
        reset = 1'b0;

        // Two sectors from sector 3.
        w0 = n_writes; d0 = n_done;
        pulse_start(23'd3, 16'd2);
        chk("busy_after_start", 32'(busy), 1);
        serve(32'h600, 512, 1, 1'b1, 8'h11);
        serve(32'h800, 512, 1, 1'b1, 8'h5A);
        wait_done(16'd2);
        repeat (5) @(posedge clk);
        #1;
        chk("done_pulses", 32'(n_done - d0), 1);
        chk("writes_2sec", 32'(n_writes - w0), 1024);
        chk("done_state_code", 32'(state_code), 5);

        // Byte strobe held high for 4 cycles per byte.
        w0 = n_writes;
        pulse_start(23'd7, 16'd1);
        serve(32'hE00, 512, 4, 1'b1, 8'h33);
        wait_done(16'd1);
        chk("writes_hold4", 32'(n_writes - w0), 512);

        // Zero sectors: done two cycles after start, no read issued.
        r0 = n_rd;
        @(posedge clk); #1;
        num_sectors = '0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("zero_done_early", 32'(done), 0);
        chk("zero_busy", 32'(busy), 1);
        @(posedge clk); #1;
        chk("zero_done", 32'(done), 1);
        chk("zero_busy_fall", 32'(busy), 0);
        chk("zero_sectors_done", 32'(sectors_done), 0);
        @(posedge clk); #1;
        chk("zero_done_single", 32'(done), 0);
        chk("zero_no_rd", 32'(n_rd - r0), 0);

        // Short sector: ready returns after 300 bytes.
        w0 = n_writes;
        pulse_start(23'd20, 16'd1);
        serve(32'h2800, 300, 1, 1'b1, 8'h77);
        wait_error();
        chk("writes_short", 32'(n_writes - w0), 300);
        pulse_start(23'd0, 16'd0);
        chk("error_cleared", 32'(error), 0);

        // Timeout: no bytes ever arrive; serve returns two cycles after RECV entry.
        pulse_start(23'd1, 16'd1);
        serve(32'h200, 0, 1, 1'b0, 8'h00);
        cnt = 2;
        while (state_code !== 3'd6 && cnt < 300) begin @(posedge clk); #1; cnt++; end
        chk("timeout_window", 32'((cnt - 1) >= 98 && (cnt - 1) <= 102), 1);
        chk("timeout_error", 32'(error), 1);
        sd_ready = 1'b1;

        // Reset while the 200th byte is being written.
        pulse_start(23'd9, 16'd1);
        serve(32'h1200, 199, 1, 1'b0, 8'h42);
        sd_dout = 8'hC3;
        sd_byte_available = 1'b1;
        @(posedge clk); #1;
        chk("pre_reset_we", 32'(mem_we), 1);
        reset = 1'b1;
        #1;
        chk("mid_reset_we", 32'(mem_we), 0);
        chk("mid_reset_busy", 32'(busy), 0);
        chk("mid_reset_state", 32'(state_code), 0);
        sd_byte_available = 1'b0;
        sd_ready = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("mid_reset_queue", 32'(exp_q.size()), 0);

        // Reset while sd_rd is asserted.
        pulse_start(23'd4, 16'd1);
        cnt = 0;
        while (sd_rd !== 1'b1 && cnt < 50) begin @(posedge clk); #1; cnt++; end
        chk("issue_rd", 32'(sd_rd), 1);
        reset = 1'b1;
        #1;
        chk("issue_reset_rd", 32'(sd_rd), 0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Fresh load after reset starts again from mem_addr 0.
        w0 = n_writes;
        pulse_start(23'd5, 16'd1);
        serve(32'hA00, 512, 1, 1'b1, 8'h99);
        wait_done(16'd1);
        chk("writes_fresh", 32'(n_writes - w0), 512);

        repeat (4) @(posedge clk);
        #1;
        chk("queue_drained", 32'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        n_bad++;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog");
    end

endmodule
